// File: rtl/btc_work_loader.sv
// Wishbone classic initiator: streams a block-header job into the miner registers,
// starts it, polls status until done and returns a nonce record.
// Optional build macro NONCE_IN_EN: 21-word jobs, word 20 goes to ADDR_NONCE_IN.
module btc_work_loader #(
  parameter logic [7:0]  ADDR_HDR_BASE = 8'h00,
  parameter logic [7:0]  ADDR_NONCE_IN = 8'h50,
  parameter logic [7:0]  ADDR_CTRL     = 8'h54,
  parameter logic [7:0]  ADDR_STATUS   = 8'h58,
  parameter logic [7:0]  ADDR_NONCE    = 8'h5C,
  parameter logic [31:0] CTRL_START    = 32'h0000_0003,
  parameter int unsigned POLL_GAP      = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] job_data,
  input  logic        job_valid,
  output logic        job_ready,
  output logic [31:0] res_nonce,
  output logic        res_found,
  output logic        res_err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic [7:0]  wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_sel,
  output logic        wb_we,
  output logic        wb_cycle,
  output logic        wb_strobe,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty
);

`ifdef NONCE_IN_EN
  localparam int unsigned NWORDS  = 21;
  localparam logic        HAS_NIN = 1'b1;
`else
  localparam int unsigned NWORDS  = 20;
  localparam logic        HAS_NIN = 1'b0;
`endif
  localparam logic [4:0]  LAST_IDX = 5'(NWORDS - 1);
  localparam int unsigned TW       = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_HDR, S_WR_CTRL, S_GAP, S_RD_STAT, S_RD_NONCE, S_RESULT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_act, r_reissue, r_live, r_found, r_err;
  logic [4:0]      r_idx;
  logic [31:0]     r_word, r_nonce;
  logic [TW-1:0]   r_tmo;
  logic [GW-1:0]   r_gap;

  logic            w_job_ready, w_accept, w_ok, w_fail, w_rty, w_start;
  logic            w_gap_done, w_hdr_last;
  logic [7:0]      w_hdr_addr;

  // Bus response decode: err > ack > rty; timeout only when nothing answered.
  always_comb begin
    w_fail      = r_act && (wb_err ||
                  (!wb_ack && !wb_rty && (r_tmo == TW'(ACK_TIMEOUT - 1))));
    w_ok        = r_act && !wb_err && wb_ack;
    w_rty       = r_act && !wb_err && !wb_ack && wb_rty;
    w_gap_done  = (r_gap == GW'(POLL_GAP - 1));
    w_hdr_last  = (r_idx == LAST_IDX);
    w_hdr_addr  = (HAS_NIN && w_hdr_last) ? ADDR_NONCE_IN
                                          : ADDR_HDR_BASE + {1'b0, r_idx, 2'b00};
    w_job_ready = r_live && ((r_state == S_IDLE) ||
                  ((r_state == S_WR_HDR) && !r_act && !r_reissue));
    w_accept    = job_valid && w_job_ready;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE:                          w_start = w_accept;
      S_WR_HDR:                        w_start = w_accept || r_reissue;
      S_WR_CTRL, S_RD_STAT, S_RD_NONCE: w_start = 1'b1;
      S_GAP:                           w_start = w_gap_done;
      default:                         w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_WR_HDR;
      S_WR_HDR:   if (w_fail) w_state_nxt = S_RESULT;
                  else if (w_ok && w_hdr_last) w_state_nxt = S_WR_CTRL;
      S_WR_CTRL:  if (w_fail) w_state_nxt = S_RESULT;
                  else if (w_ok) w_state_nxt = S_GAP;
      S_GAP:      if (w_gap_done) w_state_nxt = S_RD_STAT;
      S_RD_STAT:  if (w_fail) w_state_nxt = S_RESULT;
                  else if (w_ok) begin
                    if (!wb_rdata[0])     w_state_nxt = S_GAP;
                    else if (wb_rdata[1]) w_state_nxt = S_RD_NONCE;
                    else                  w_state_nxt = S_RESULT;
                  end
      S_RD_NONCE: if (w_fail || w_ok) w_state_nxt = S_RESULT;
      S_RESULT:   if (res_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_live    <= 1'b0;
      r_act     <= 1'b0;
      r_reissue <= 1'b0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
      r_word    <= '0;
      r_nonce   <= '0;
      r_found   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      // Every completed or retried access falls back to one idle cycle before the next.
      if (r_act) begin
        r_tmo <= r_tmo + TW'(1);
        if (w_ok || w_fail || w_rty) r_act <= 1'b0;
        if (w_rty) r_reissue <= 1'b1;
      end else begin
        r_tmo <= '0;
        if (w_start) begin
          r_act     <= 1'b1;
          r_reissue <= 1'b0;
        end
      end

      if (w_accept) r_word <= job_data;

      if (r_state != S_WR_HDR)           r_idx <= '0;
      else if (w_ok && !w_hdr_last)      r_idx <= r_idx + 5'd1;

      if (r_state == S_GAP) r_gap <= r_gap + GW'(1);
      else                  r_gap <= '0;

      if ((r_state == S_IDLE) && w_accept) begin
        r_nonce <= '0;
        r_found <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_fail) begin
        r_nonce <= '0;
        r_found <= 1'b0;
        r_err   <= 1'b1;
      end else if ((r_state == S_RD_STAT) && w_ok && wb_rdata[0] && !wb_rdata[1]) begin
        r_nonce <= '0;
        r_found <= 1'b0;
      end else if ((r_state == S_RD_NONCE) && w_ok) begin
        r_nonce <= wb_rdata;
        r_found <= 1'b1;
      end
    end
  end

  always_comb begin
    job_ready = w_job_ready;
    busy      = (r_state != S_IDLE);
    res_valid = (r_state == S_RESULT);
    res_nonce = r_nonce;
    res_found = r_found;
    res_err   = r_err;
    wb_cycle  = r_act;
    wb_strobe = r_act;
    wb_sel    = r_act ? 4'hF : 4'h0;
    wb_cti    = '0;
    wb_bte    = '0;
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_wdata  = '0;
    if (r_act) begin
      unique case (r_state)
        S_WR_HDR: begin
          wb_we    = 1'b1;
          wb_addr  = w_hdr_addr;
          wb_wdata = r_word;
        end
        S_WR_CTRL: begin
          wb_we    = 1'b1;
          wb_addr  = ADDR_CTRL;
          wb_wdata = CTRL_START;
        end
        S_RD_STAT:  wb_addr = ADDR_STATUS;
        S_RD_NONCE: wb_addr = ADDR_NONCE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btc_work_loader.sv
// Randomized bench for btc_work_loader: scripted Wishbone slave, access log and
// a transaction-level model of the expected bus traffic and result record.
module tb_btc_work_loader;
  localparam int unsigned POLL_GAP    = 16;
  localparam int unsigned ACK_TIMEOUT = 255;
`ifdef NONCE_IN_EN
  localparam int NW = 21;
`else
  localparam int NW = 20;
`endif
  localparam int K_ACK = 0, K_RTY = 1, K_ERR = 2, K_TMO = 3;

  logic        clk, arst_n;
  logic [31:0] job_data;
  logic        job_valid, job_ready;
  logic [31:0] res_nonce;
  logic        res_found, res_err, res_valid, res_ready, busy;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cycle, wb_strobe, wb_ack, wb_err, wb_rty;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;

  btc_work_loader #(.POLL_GAP(POLL_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n), .job_data(job_data), .job_valid(job_valid),
    .job_ready(job_ready), .res_nonce(res_nonce), .res_found(res_found),
    .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cycle(wb_cycle), .wb_strobe(wb_strobe), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_rdata(wb_rdata), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] data;
    int          kind;
    int          hold;
    int          idle;
  } acc_t;

  acc_t        log_q[$];
  acc_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] words[21];

  int          cfg_rty_idx = -1, cfg_err_idx = -1, cfg_nzero = 0, cfg_maxd = 0;
  bit          cfg_noack = 0;
  logic [31:0] cfg_final = 32'h3, cfg_nonce = '0;
  int          zeros_left = 0, wait_c = 0, hold_c = 0, idle_c = 0;
  bit          rty_done = 0, in_acc = 0, chk_en = 0;
  acc_t        cur;
  logic [31:0] zval;
  logic [31:0] got_nonce;
  logic        got_found, got_err;

  function automatic logic [7:0] haddr(input int i);
    if (i == 20) return 8'h50;
    return 8'(4 * i);
  endfunction

  function automatic acc_t mk(input logic [7:0] a, input logic we, input logic [31:0] d, input int k);
    acc_t r;
    r.addr = a; r.we = we; r.data = d; r.kind = k; r.hold = 0; r.idle = 0;
    return r;
  endfunction

  function automatic int count_addr(input logic [7:0] a);
    int n = 0;
    foreach (log_q[k]) if (log_q[k].addr == a) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scripted miner slave: random wait states, optional retry/error/no-ack, logs each access.
  always @(negedge clk) begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    if (wb_cycle === 1'b1) begin
      if (!in_acc) begin
        in_acc = 1; hold_c = 0;
        cur.addr = wb_addr; cur.we = wb_we; cur.data = wb_wdata; cur.idle = idle_c;
        idle_c = 0;
        wait_c = $urandom_range(cfg_maxd, 0);
      end
      hold_c++;
      if (wait_c > 0) wait_c--;
      else if (!(cfg_noack && wb_addr == 8'h54)) begin
        cur.hold = hold_c;
        if (wb_we && cfg_err_idx >= 0 && wb_addr == haddr(cfg_err_idx)) begin
          wb_err = 1'b1; cur.kind = K_ERR;
        end else if (wb_we && cfg_rty_idx >= 0 && !rty_done && wb_addr == haddr(cfg_rty_idx)) begin
          wb_rty = 1'b1; rty_done = 1; cur.kind = K_RTY;
        end else begin
          wb_ack = 1'b1; cur.kind = K_ACK;
          if (!wb_we && wb_addr == 8'h58) begin
            if (zeros_left > 0) begin
              zval = $urandom; zval[0] = 1'b0; wb_rdata = zval; zeros_left--;
            end else wb_rdata = cfg_final;
          end else if (!wb_we && wb_addr == 8'h5C) wb_rdata = cfg_nonce;
          else wb_rdata = $urandom;
        end
        log_q.push_back(cur);
        in_acc = 0;
      end
    end else begin
      if (in_acc) begin
        cur.hold = hold_c; cur.kind = K_TMO;
        log_q.push_back(cur);
        in_acc = 0;
      end
      idle_c++;
    end
  end

  // Per-cycle protocol and result-stability checks.
  logic        p_rv = 0, p_rr = 0, p_found = 0, p_err = 0;
  logic [31:0] p_nonce = '0;
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("wb_sel", {28'h0, wb_sel}, wb_cycle ? 32'hF : 32'h0);
      chk("wb_strobe", {31'h0, wb_strobe}, {31'h0, wb_cycle});
      chk("wb_cti_bte", {27'h0, wb_cti, wb_bte}, 32'h0);
      if (res_valid) begin
        chk("job_ready_in_result", {31'h0, job_ready}, 32'h0);
        chk("busy_in_result", {31'h0, busy}, 32'h1);
        if (p_rv && !p_rr) begin
          chk("res_nonce_stable", res_nonce, p_nonce);
          chk("res_flags_stable", {30'h0, res_found, res_err}, {30'h0, p_found, p_err});
        end
      end
    end
    p_rv = res_valid; p_rr = res_ready;
    p_nonce = res_nonce; p_found = res_found; p_err = res_err;
  end

  task automatic run_job(input int hold_cycles);
    bit          e_found, e_err, abort;
    logic [31:0] e_nonce;
    int          i, budget, exp_words, n;
    exp_q.delete();
    e_found = 0; e_err = 0; e_nonce = '0; abort = 0; exp_words = NW;
    for (int k = 0; k < NW && !abort; k++) begin
      if (cfg_err_idx == k) begin
        exp_q.push_back(mk(haddr(k), 1'b1, words[k], K_ERR));
        e_err = 1; abort = 1; exp_words = k + 1;
      end else begin
        if (cfg_rty_idx == k) exp_q.push_back(mk(haddr(k), 1'b1, words[k], K_RTY));
        exp_q.push_back(mk(haddr(k), 1'b1, words[k], K_ACK));
      end
    end
    if (!abort) begin
      if (cfg_noack) begin
        exp_q.push_back(mk(8'h54, 1'b1, 32'h3, K_TMO));
        e_err = 1;
      end else begin
        exp_q.push_back(mk(8'h54, 1'b1, 32'h3, K_ACK));
        for (int k = 0; k <= cfg_nzero; k++) exp_q.push_back(mk(8'h58, 1'b0, '0, K_ACK));
        if (cfg_final[1]) begin
          exp_q.push_back(mk(8'h5C, 1'b0, '0, K_ACK));
          e_found = 1; e_nonce = cfg_nonce;
        end
      end
    end

    zeros_left = cfg_nzero; rty_done = 0; log_q.delete();
    i = 0; budget = 0;
    while (i < NW && budget < 4000 && !res_valid) begin
      @(negedge clk);
      job_data  = words[i];
      job_valid = ($urandom_range(3, 0) != 0);
      if (job_valid && job_ready) i++;
      budget++;
    end
    @(negedge clk);
    job_valid = 1'b0; job_data = $urandom;
    chk("words_accepted", i, exp_words);

    budget = 0;
    while (!res_valid && budget < 20000) begin
      @(negedge clk); budget++;
    end
    chk("res_valid_seen", {31'h0, res_valid}, 32'h1);
    got_nonce = res_nonce; got_found = res_found; got_err = res_err;
    chk("res_found", {31'h0, res_found}, {31'h0, e_found});
    chk("res_err", {31'h0, res_err}, {31'h0, e_err});
    chk("res_nonce", res_nonce, e_nonce);

    res_ready = 1'b0;
    repeat (hold_cycles) @(negedge clk);
    chk("res_valid_held", {31'h0, res_valid}, 32'h1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_cleared", {31'h0, res_valid}, 32'h0);
    chk("busy_after_result", {31'h0, busy}, 32'h0);
    chk("job_ready_after_result", {31'h0, job_ready}, 32'h1);
    repeat (2) @(negedge clk);

    chk("n_access", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk("acc_addr", {24'h0, log_q[k].addr}, {24'h0, exp_q[k].addr});
      chk("acc_we", {31'h0, log_q[k].we}, {31'h0, exp_q[k].we});
      chk("acc_kind", log_q[k].kind, exp_q[k].kind);
      if (exp_q[k].we) chk("acc_wdata", log_q[k].data, exp_q[k].data);
      if (k > 0) chk("acc_idle_gap", {31'h0, log_q[k].idle >= 1}, 32'h1);
      if (exp_q[k].addr == 8'h58) chk("poll_gap", {31'h0, log_q[k].idle >= POLL_GAP}, 32'h1);
      if (exp_q[k].kind == K_TMO) chk("timeout_cycles", log_q[k].hold, ACK_TIMEOUT);
    end
  endtask

  task automatic clear_cfg();
    cfg_rty_idx = -1; cfg_err_idx = -1; cfg_nzero = 0; cfg_maxd = 0;
    cfg_noack = 0; cfg_final = 32'h3; cfg_nonce = $urandom;
  endtask

  initial begin
    int budget, i;
    arst_n = 1'b1; job_valid = 1'b0; job_data = '0; res_ready = 1'b0;
    wb_rdata = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    #1 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_job_ready", {31'h0, job_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_wb_cycle", {31'h0, wb_cycle}, 32'h0);
    chk("rst_res", {res_nonce[29:0], res_found, res_err}, 32'h0);
    arst_n = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // Full job, 1-cycle ack, two not-done polls then done+found.
    clear_cfg();
    for (int k = 0; k < 21; k++) words[k] = 32'h1000_0000 + k;
    cfg_nzero = 2; cfg_final = 32'h3; cfg_nonce = 32'hDEAD_BEEF;
    run_job(10);
    if (log_q.size() == exp_q.size()) begin
      chk("t1_w0_addr", {24'h0, log_q[0].addr}, 32'h00);
      chk("t1_w19_addr", {24'h0, log_q[19].addr}, 32'h4C);
      chk("t1_w19_data", log_q[19].data, 32'h1000_0013);
      chk("t1_ctrl_addr", {24'h0, log_q[NW].addr}, 32'h54);
      chk("t1_ctrl_data", log_q[NW].data, 32'h3);
    end
    chk("t1_status_reads", count_addr(8'h58), 3);
    chk("t1_nonce_reads", count_addr(8'h5C), 1);
    chk("t1_nonce", got_nonce, 32'hDEAD_BEEF);
    chk("t1_found", {31'h0, got_found}, 32'h1);

    // Done without nonce_found.
    clear_cfg();
    cfg_final = 32'h1;
    run_job(2);
    chk("t2_nonce_reads", count_addr(8'h5C), 0);
    chk("t2_result", {got_nonce[29:0], got_found, got_err}, 32'h0);

    // Retry on header word 5.
    clear_cfg();
    cfg_rty_idx = 5; cfg_maxd = 1;
    run_job(1);
    chk("t3_addr14_count", count_addr(8'h14), 2);
    if (log_q.size() > 6) begin
      chk("t3_rty_kind", log_q[5].kind, K_RTY);
      chk("t3_reissue_data", log_q[6].data, 32'h1000_0005);
    end

    // Control write never acknowledged.
    clear_cfg();
    cfg_noack = 1;
    run_job(0);
    chk("t4_err", {31'h0, got_err}, 32'h1);
    if (log_q.size() > 0) chk("t4_hold", log_q[log_q.size()-1].hold, 255);

    // Bus error on a random header word.
    clear_cfg();
    for (int k = 0; k < 21; k++) words[k] = $urandom;
    cfg_err_idx = $urandom_range(NW - 1, 0); cfg_maxd = 2;
    run_job(3);

    // Asynchronous reset during word 7's access.
    clear_cfg();
    cfg_maxd = 3; log_q.delete();
    i = 0; budget = 0;
    while (i < 8 && budget < 2000) begin
      @(negedge clk);
      job_data = words[i]; job_valid = 1'b1;
      if (job_ready) i++;
      budget++;
    end
    @(negedge clk);
    job_valid = 1'b0;
    chk("t6_cyc_before_rst", {31'h0, wb_cycle}, 32'h1);
    chk("t6_addr_before_rst", {24'h0, wb_addr}, 32'h1C);
    #3 arst_n = 1'b0;
    #1;
    chk("t6_cyc_async_drop", {31'h0, wb_cycle}, 32'h0);
    chk("t6_busy_in_rst", {31'h0, busy}, 32'h0);
    chk("t6_ready_in_rst", {31'h0, job_ready}, 32'h0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_ready_after_rst", {31'h0, job_ready}, 32'h1);
    chk("t6_busy_after_rst", {31'h0, busy}, 32'h0);
    clear_cfg();
    for (int k = 0; k < 21; k++) words[k] = $urandom;
    run_job(0);
    if (log_q.size() > 0) chk("t6_first_addr", {24'h0, log_q[0].addr}, 32'h00);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      clear_cfg();
      for (int k = 0; k < 21; k++) words[k] = $urandom;
      cfg_maxd  = $urandom_range(3, 0);
      cfg_nzero = $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 1) cfg_rty_idx = $urandom_range(NW - 1, 0);
      if ($urandom_range(5, 0) == 0) cfg_err_idx = $urandom_range(NW - 1, 0);
      cfg_noack = ($urandom_range(7, 0) == 0);
      cfg_final = $urandom;
      cfg_final[0] = 1'b1;
      run_job($urandom_range(5, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
